game_mode_ctrl: RTL and testbench
=================================

# game_mode_ctrl

Top-level game sequencer that produces the `game_mode` value consumed by the screen-select draw stage. It takes the raw start button and the per-player death flags from game logic and decides START / GAME / PLAYER1_WIN / PLAYER2_WIN. All mode changes are aligned to the start of vertical blanking, so the display never switches screens mid-frame. It also issues a one-cycle `game_rst` pulse that re-initialises map and player logic when a round begins.

## Interface
- `DEBOUNCE_CYCLES`, default 65000: consecutive stable `clk` cycles needed to accept a new button level (1 ms at 65 MHz).
- `WIN_HOLD_FRAMES`, default 180: number of frame ticks a win screen is held before returning to START.
- `clk`  in  1  pixel clock (65 MHz domain); one clock only.
- `rst`  in  1  reset, asynchronous, active-high.
- `start_btn`  in  1  raw, asynchronous push-button, active-high.
- `p1_dead`  in  1  player 1 death flag from game logic, sync to `clk`, level or pulse.
- `p2_dead`  in  1  player 2 death flag, same rules as `p1_dead`.
- `vblnk`  in  1  vertical blank from the VGA timing stage, sync to `clk`.
- `mode`  out  game_mode  current screen, registered.
- `game_rst`  out  1  one-cycle pulse marking the start of a new round.

## Operation
- **Button path:** 2-FF synchroniser, then debounce.
  - The debounce counter resets whenever the synced level differs from the accepted level.
  - When the counter reaches `DEBOUNCE_CYCLES`, the accepted level takes the synced level.
  - `press` = rising edge of the accepted level, one cycle wide.
- **Frame tick:** `vblnk_d` registers `vblnk`; `frame_tick = vblnk & ~vblnk_d`.
- **Pending latches** (all cleared by reset):
  - `start_req`: set by `press` while in START; cleared when GAME is entered.
  - `p1_dead_l` / `p2_dead_l`: set by the corresponding input while in GAME; both cleared when GAME is entered. Inputs are ignored in every other mode.
- **State machine** (state register is `mode`; transitions are taken only on cycles where `frame_tick` = 1):
  - **START:**
    - `start_req` → GAME.
    - `game_rst` = 1 on the same edge as the transition.
  - **GAME:**
    - `p2_dead_l` & ~`p1_dead_l` → PLAYER1_WIN.
    - `p1_dead_l` & ~`p2_dead_l` → PLAYER2_WIN.
    - both set → START (draw, no winner).
    - neither set → stay.
  - **PLAYER1_WIN / PLAYER2_WIN:**
    - `hold_cnt` increments on each `frame_tick`.
    - When `hold_cnt` = `WIN_HOLD_FRAMES-1` on a tick → START, and `hold_cnt` clears.
    - `press` in these states is discarded; it does not set `start_req`.
  - Any illegal encoding → START on the next clock edge, regardless of `frame_tick`.
- **Counter widths:**
  - `hold_cnt` is `$clog2(WIN_HOLD_FRAMES+1)` bits.
  - The debounce counter is `$clog2(DEBOUNCE_CYCLES+1)` bits.
  - Neither counter wraps: the debounce counter saturates; `hold_cnt` clears on exit from a win state.

## Timing
- **Reset values:** `mode`=START, `game_rst`=0, `start_req`/`p*_dead_l`=0, `hold_cnt`=0, debounce counter=0, accepted button level=0, `vblnk_d`=0.
- **Reset is asynchronous:** asserting `rst` mid-round forces `mode`=START immediately, with no `frame_tick` wait. If `vblnk` is already high at release, the first cycle after release produces a tick.
- **Button latency:** `press` is asserted 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles after a clean button edge.
- **Mode change latency:** `mode` takes its new value at the clock edge ending the first cycle in which `vblnk`=1. It is visible one cycle after `vblnk` rises, and constant for the rest of the frame.
- **Death inputs:** a death pulse of any width ≥1 cycle arriving during GAME is latched. A death pulse and `frame_tick` in the same cycle are not seen at that tick; they take effect at the next `frame_tick`.
- **`game_rst`:** high for exactly one cycle, coincident with the first cycle `mode`=GAME.
- **Press and tick in the same cycle in START:** `start_req` is set; the transition happens at the next tick.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4 and `WIN_HOLD_FRAMES`=3, with `vblnk` high for 10 of every 100 cycles.

1. **Reset:** assert `rst` asynchronously mid-cycle → `mode`=START and `game_rst`=0 before the next clock edge; all latches are 0 after release.
2. **Bounce and start:** `start_btn` toggles every 2 cycles for 20 cycles, then is held high → no `press` during bouncing. Exactly one `press` arrives 7 cycles after the hold begins. `mode`=GAME one cycle after the next `vblnk` rise, with `game_rst` high for 1 cycle at that point.
3. **P2 death:** in GAME, 1-cycle `p2_dead` pulse at cycle 30 of a frame → `mode` stays GAME until the next `vblnk` rise, then PLAYER1_WIN. After 3 further ticks → START. A `start_btn` press during the win screen produces no GAME entry.
4. **Simultaneous deaths:** `p1_dead` and `p2_dead` both pulse in the same cycle → next tick `mode`=START; no win screen.
5. **Tick collision:** `p1_dead` pulses in the same cycle as `frame_tick` → `mode` stays GAME at that tick, becomes PLAYER2_WIN at the following tick.
6. **Reset mid-round:** in PLAYER2_WIN with `hold_cnt`=2, pulse `rst` → `mode`=START, `hold_cnt`=0; a new start press re-enters GAME normally.

Source files
------------

// File: rtl/game_mode_ctrl.sv
// game_mode_ctrl: top-level screen sequencer. Debounces the start button,
// latches death events, and steps START/GAME/win screens only at the start
// of vertical blanking. Emits a one-cycle game_rst when a round begins.

package game_mode_pkg;
  typedef enum logic [1:0] {
    START       = 2'd0,
    GAME        = 2'd1,
    PLAYER1_WIN = 2'd2,
    PLAYER2_WIN = 2'd3
  } game_mode;
endpackage

module game_mode_ctrl
  import game_mode_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65000,
  parameter int WIN_HOLD_FRAMES = 180
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     start_btn,
  input  logic     p1_dead,
  input  logic     p2_dead,
  input  logic     vblnk,
  output game_mode mode,
  output logic     game_rst
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(WIN_HOLD_FRAMES + 1);
  localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WIN_HOLD_FRAMES - 1);

  // Counter increment that holds at DB_MAX instead of wrapping.
  function automatic logic [DB_W-1:0] db_sat_inc(input logic [DB_W-1:0] v);
    return (v == DB_MAX) ? v : v + 1'b1;
  endfunction

  logic              btn_p0;
  logic              btn_p1;
  logic              btn_acc;
  logic              btn_acc_d;
  logic [DB_W-1:0]   db_cnt;
  logic              press;
  logic              vblnk_d;
  logic              frame_tick;
  logic              start_req;
  logic              p1_dead_l;
  logic              p2_dead_l;
  logic [HOLD_W-1:0] hold_cnt;
  logic              in_win;
  game_mode          mode_nxt;
  logic              game_rst_nxt;
  logic              enter_game;

  // Two-flop synchroniser for the asynchronous push-button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
    end else begin
      btn_p0 <= start_btn;
      btn_p1 <= btn_p0;
    end
  end

  // Debounce: accept the synced level only after it has differed from the
  // accepted level for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt    <= '0;
      btn_acc   <= 1'b0;
      btn_acc_d <= 1'b0;
    end else begin
      btn_acc_d <= btn_acc;
      if (btn_p1 == btn_acc) begin
        db_cnt <= '0;
      end else begin
        db_cnt <= db_sat_inc(db_cnt);
        if (db_cnt == DB_MAX) btn_acc <= btn_p1;
      end
    end
  end

  assign press      = btn_acc & ~btn_acc_d;
  assign frame_tick = vblnk & ~vblnk_d;
  assign in_win     = (mode == PLAYER1_WIN) || (mode == PLAYER2_WIN);
  assign enter_game = game_rst_nxt;

  // Delayed vblnk for rising-edge (start of blanking) detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vblnk_d <= 1'b0;
    else     vblnk_d <= vblnk;
  end

  // Pending requests, held until the next frame tick can act on them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_req <= 1'b0;
      p1_dead_l <= 1'b0;
      p2_dead_l <= 1'b0;
    end else if (enter_game) begin
      start_req <= 1'b0;
      p1_dead_l <= 1'b0;
      p2_dead_l <= 1'b0;
    end else begin
      if (press && (mode == START)) start_req <= 1'b1;
      if (mode == GAME) begin
        if (p1_dead) p1_dead_l <= 1'b1;
        if (p2_dead) p2_dead_l <= 1'b1;
      end
    end
  end

  // Win-screen frame counter; cleared whenever no win screen is showing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (in_win) begin
      if (frame_tick) hold_cnt <= (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + 1'b1;
    end else begin
      hold_cnt <= '0;
    end
  end

  // Mode state register and registered round-start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode     <= START;
      game_rst <= 1'b0;
    end else begin
      mode     <= mode_nxt;
      game_rst <= game_rst_nxt;
    end
  end

  // Next-mode logic; legal transitions only on a frame tick.
  always_comb begin
    mode_nxt     = mode;
    game_rst_nxt = 1'b0;
    case (mode)
      START: begin
        if (frame_tick && start_req) begin
          mode_nxt     = GAME;
          game_rst_nxt = 1'b1;
        end
      end
      GAME: begin
        if (frame_tick) begin
          case ({p1_dead_l, p2_dead_l})
            2'b01:   mode_nxt = PLAYER1_WIN;
            2'b10:   mode_nxt = PLAYER2_WIN;
            2'b11:   mode_nxt = START;
            default: mode_nxt = GAME;
          endcase
        end
      end
      PLAYER1_WIN, PLAYER2_WIN: begin
        if (frame_tick && (hold_cnt == HOLD_LAST)) mode_nxt = START;
      end
      default: mode_nxt = START;
    endcase
  end

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Bench for game_mode_ctrl: 100-cycle frames with vblnk high for the first
// 10 cycles; expected mode changes are queued as stimulus is applied and
// popped when the DUT changes mode.
module tb_game_mode_ctrl;
  import game_mode_pkg::*;

  localparam int DB = 4;
  localparam int WH = 3;

  logic     clk       = 1'b0;
  logic     rst       = 1'b0;
  logic     start_btn = 1'b0;
  logic     p1_dead   = 1'b0;
  logic     p2_dead   = 1'b0;
  logic     vblnk     = 1'b0;
  game_mode mode;
  logic     game_rst;

  int n_tests = 0;
  int n_fail  = 0;
  int pos     = 50;
  int cyc     = 0;
  game_mode exp_q[$];

  game_mode_ctrl #(.DEBOUNCE_CYCLES(DB), .WIN_HOLD_FRAMES(WH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_btn (start_btn),
    .p1_dead   (p1_dead),
    .p2_dead   (p2_dead),
    .vblnk     (vblnk),
    .mode      (mode),
    .game_rst  (game_rst)
  );

  always #5 clk = ~clk;

  // Frame timing: pos is the cycle index within the frame, updated just after each posedge.
  initial begin : frame_gen
    forever begin
      @(posedge clk);
      #2;
      pos   = (pos + 1) % 100;
      cyc   = cyc + 1;
      vblnk = (pos < 10);
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_pos(input int p);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pos == p) return;
    end
  endtask

  task automatic wait_change(input int budget, output int cycles, output bit to);
    game_mode ref_m;
    ref_m  = mode;
    to     = 1'b1;
    cycles = budget;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (mode !== ref_m) begin
        cycles = i;
        to     = 1'b0;
        return;
      end
    end
  endtask

  task automatic start_round(input string tag);
    int cycles;
    bit to;
    game_mode exp;
    wait_pos(20);
    start_btn = 1'b1;
    exp_q.push_back(GAME);
    repeat (12) @(negedge clk);
    start_btn = 1'b0;
    wait_change(250, cycles, to);
    exp = exp_q.pop_front();
    n_tests++;
    if (to || mode !== exp) begin
      n_fail++;
      $display("FAIL %s_mode: got %0d after %0d cycles, expected %0d", tag, mode, cycles, exp);
    end
    n_tests++;
    if (pos != 1) begin
      n_fail++;
      $display("FAIL %s_timing: change seen at frame pos %0d, expected 1", tag, pos);
    end
    n_tests++;
    if (game_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_game_rst: got %b expected 1", tag, game_rst);
    end
    @(negedge clk);
    n_tests++;
    if (game_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_game_rst_width: got %b expected 0", tag, game_rst);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (mode !== START) begin
      n_fail++;
      $display("FAIL reset_async_mode: got %0d expected %0d", mode, START);
    end
    n_tests++;
    if (game_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async_game_rst: got %b expected 0", game_rst);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({dut.start_req, dut.p1_dead_l, dut.p2_dead_l, dut.btn_acc} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_latches: got %b expected 0000",
               {dut.start_req, dut.p1_dead_l, dut.p2_dead_l, dut.btn_acc});
    end
    n_tests++;
    if (dut.hold_cnt !== '0 || mode !== START) begin
      n_fail++;
      $display("FAIL reset_state: hold_cnt %0d mode %0d, expected 0 and %0d", dut.hold_cnt, mode, START);
    end
  endtask

  task automatic test_bounce_start();
    int presses = 0;
    int first   = -1;
    int cycles;
    bit to;
    game_mode exp;
    wait_pos(20);
    for (int s = 0; s < 10; s++) begin
      start_btn = ~start_btn;
      repeat (2) begin
        @(negedge clk);
        if (dut.press) presses++;
      end
    end
    n_tests++;
    if (presses != 0) begin
      n_fail++;
      $display("FAIL bounce_no_press: got %0d presses expected 0", presses);
    end
    start_btn = 1'b1;
    exp_q.push_back(GAME);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (dut.press) begin
        presses++;
        if (first < 0) first = k;
      end
    end
    n_tests++;
    if (presses != 1) begin
      n_fail++;
      $display("FAIL press_count: got %0d expected 1", presses);
    end
    n_tests++;
    if (first != 2 + DB + 1) begin
      n_fail++;
      $display("FAIL press_latency: got %0d expected %0d", first, 2 + DB + 1);
    end
    n_tests++;
    if (dut.start_req !== 1'b1) begin
      n_fail++;
      $display("FAIL start_req_set: got %b expected 1", dut.start_req);
    end
    start_btn = 1'b0;
    wait_change(250, cycles, to);
    exp = exp_q.pop_front();
    n_tests++;
    if (to || mode !== exp) begin
      n_fail++;
      $display("FAIL start_mode: got %0d after %0d cycles, expected %0d", mode, cycles, exp);
    end
    n_tests++;
    if (pos != 1 || game_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL start_timing: pos %0d game_rst %b, expected pos 1 game_rst 1", pos, game_rst);
    end
    @(negedge clk);
    n_tests++;
    if (game_rst !== 1'b0 || dut.start_req !== 1'b0) begin
      n_fail++;
      $display("FAIL start_cleanup: game_rst %b start_req %b, expected 0 0", game_rst, dut.start_req);
    end
  endtask

  task automatic test_p2_death();
    int cycles;
    int t_enter;
    bit to;
    game_mode exp;
    wait_pos(30);
    p2_dead = 1'b1;
    exp_q.push_back(PLAYER1_WIN);
    @(negedge clk);
    p2_dead = 1'b0;
    wait_change(120, cycles, to);
    t_enter = cyc;
    exp = exp_q.pop_front();
    n_tests++;
    if (to || mode !== exp) begin
      n_fail++;
      $display("FAIL p2_death_mode: got %0d after %0d cycles, expected %0d", mode, cycles, exp);
    end
    n_tests++;
    if (pos != 1) begin
      n_fail++;
      $display("FAIL p2_death_timing: change at pos %0d expected 1", pos);
    end
    exp_q.push_back(START);
    wait_pos(20);
    start_btn = 1'b1;
    repeat (12) @(negedge clk);
    start_btn = 1'b0;
    n_tests++;
    if (dut.start_req !== 1'b0) begin
      n_fail++;
      $display("FAIL win_press_discard: start_req %b expected 0", dut.start_req);
    end
    wait_change(350, cycles, to);
    exp = exp_q.pop_front();
    n_tests++;
    if (to || mode !== exp) begin
      n_fail++;
      $display("FAIL win_exit_mode: got %0d expected %0d", mode, exp);
    end
    n_tests++;
    if (cyc - t_enter != 100 * WH) begin
      n_fail++;
      $display("FAIL win_hold_len: got %0d cycles expected %0d", cyc - t_enter, 100 * WH);
    end
    wait_change(150, cycles, to);
    n_tests++;
    if (!to) begin
      n_fail++;
      $display("FAIL win_no_reentry: mode changed to %0d after %0d cycles, expected no change", mode, cycles);
    end
  endtask

  task automatic test_simultaneous();
    int cycles;
    bit to;
    game_mode exp;
    start_round("sim_entry");
    wait_pos(40);
    p1_dead = 1'b1;
    p2_dead = 1'b1;
    exp_q.push_back(START);
    @(negedge clk);
    p1_dead = 1'b0;
    p2_dead = 1'b0;
    wait_change(120, cycles, to);
    exp = exp_q.pop_front();
    n_tests++;
    if (to || mode !== exp) begin
      n_fail++;
      $display("FAIL draw_mode: got %0d after %0d cycles, expected %0d", mode, cycles, exp);
    end
    n_tests++;
    if (pos != 1) begin
      n_fail++;
      $display("FAIL draw_timing: change at pos %0d expected 1", pos);
    end
  endtask

  task automatic test_tick_collision();
    int cycles;
    int t0;
    bit to;
    game_mode exp;
    start_round("coll_entry");
    wait_pos(0);
    p1_dead = 1'b1;
    t0 = cyc;
    exp_q.push_back(PLAYER2_WIN);
    @(negedge clk);
    p1_dead = 1'b0;
    n_tests++;
    if (mode !== GAME) begin
      n_fail++;
      $display("FAIL collision_hold: got %0d expected %0d", mode, GAME);
    end
    wait_change(150, cycles, to);
    exp = exp_q.pop_front();
    n_tests++;
    if (to || mode !== exp) begin
      n_fail++;
      $display("FAIL collision_mode: got %0d after %0d cycles, expected %0d", mode, cycles, exp);
    end
    n_tests++;
    if (cyc - t0 != 101) begin
      n_fail++;
      $display("FAIL collision_delay: got %0d cycles expected 101", cyc - t0);
    end
  endtask

  task automatic test_reset_midround();
    wait_pos(0);
    wait_pos(0);
    wait_pos(5);
    n_tests++;
    if (mode !== PLAYER2_WIN || dut.hold_cnt !== 2'd2) begin
      n_fail++;
      $display("FAIL midround_setup: mode %0d hold_cnt %0d, expected %0d and 2", mode, dut.hold_cnt, PLAYER2_WIN);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (mode !== START || dut.hold_cnt !== '0 || game_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL midround_reset: mode %0d hold_cnt %0d game_rst %b, expected %0d 0 0",
               mode, dut.hold_cnt, game_rst, START);
    end
    @(negedge clk);
    rst = 1'b0;
    start_round("reset_reentry");
  endtask

  initial begin : main
    test_reset();
    test_bounce_start();
    test_p2_death();
    test_simultaneous();
    test_tick_collision();
    test_reset_midround();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
